// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle unsigned arithmetic unit (add, sub, shift-add
// multiply, restoring divide) behind a start/busy/done handshake.
// Operands are latched on accept so the caller may change them while busy.
// The result and flag registers change only on the edge that enters DONE.

module seq_calculator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    // Counter value during the final multiply/divide iteration.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Control state.
    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Latched operands.
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;

    // Multiply working registers: accumulator, shifted multiplicand and
    // multiplier consumed LSB first.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mpl_q, mpl_d;

    // Divide working registers: remainder and dividend/quotient shift
    // register (dividend bits leave at the top, quotient bits enter at the
    // bottom).
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;

    // Architectural outputs.
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               flag_q, flag_d;

    // Datapath terms.
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   trial;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               last_iter;
    logic               div_by_zero;
    logic               load;

    // Single-cycle results: the carry/borrow land in bit WIDTH.
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = {1'b0, a_q} - {1'b0, b_q};

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set.
    assign acc_step = acc_q + (mpl_q[0] ? mcand_q : '0);

    // One restoring-divide step on the WIDTH+1-bit partial remainder. When
    // the subtraction fits the true difference is below b, so a WIDTH-bit
    // subtract gives the exact new remainder.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign fits     = (shifted >= {1'b0, b_q});
    assign trial    = shifted[WIDTH-1:0] - b_q;
    assign rem_step = fits ? trial : shifted[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], fits};

    assign last_iter   = (cnt_q == LAST_ITER);
    assign div_by_zero = (b_q == '0);

    // Next-state and datapath control for the IDLE/CALC/DONE sequencer.
    always_comb begin
        // NOTE: every _d starts from its _q value so that no path through
        // this block leaves a signal unassigned and infers a latch.
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mpl_d    = mpl_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        flag_d   = flag_q;
        load     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end

            S_CALC: begin
                unique case (op_q)
                    OP_ADD: begin
                        result_d = {{(WIDTH-1){1'b0}}, sum_w};
                        flag_d   = 1'b0;
                        state_d  = S_DONE;
                    end

                    OP_SUB: begin
                        result_d = {{(WIDTH-1){1'b0}}, diff_w};
                        flag_d   = diff_w[WIDTH];
                        state_d  = S_DONE;
                    end

                    OP_MUL: begin
                        acc_d   = acc_step;
                        mcand_d = mcand_q << 1;
                        mpl_d   = mpl_q >> 1;
                        cnt_d   = cnt_q + 1'b1;
                        if (last_iter) begin
                            result_d = acc_step;
                            flag_d   = 1'b0;
                            state_d  = S_DONE;
                        end
                    end

                    OP_DIV: begin
                        if (div_by_zero) begin
                            // No iterations: quotient saturates, remainder is the dividend.
                            result_d = {a_q, {WIDTH{1'b1}}};
                            flag_d   = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            rem_d = rem_step;
                            quo_d = quo_step;
                            cnt_d = cnt_q + 1'b1;
                            if (last_iter) begin
                                result_d = {rem_step, quo_step};
                                flag_d   = 1'b0;
                                state_d  = S_DONE;
                            end
                        end
                    end

                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end

            S_DONE: begin
                // A start here is accepted immediately, giving back-to-back operation.
                if (start) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accepting a request latches the operands and primes both
        // iterative datapaths; only the one selected by op is used.
        if (load) begin
            state_d = S_CALC;
            op_d    = op_t'(op);
            a_d     = a;
            b_d     = b;
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, a};
            mpl_d   = b;
            rem_d   = '0;
            quo_d   = a;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mpl_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mpl_q    <= mpl_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign flag   = flag_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator (WIDTH=8): table-driven vectors
// with literal expectations, random vectors scored against an arithmetic
// reference model, plus hand-written handshake and reset sequences.

module tb_seq_calculator;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           flag;

    typedef struct {
        logic [2*W-1:0] result;
        logic           flag;
        int             lat;
    } exp_t;

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] result;
        logic           flag;
        int             lat;
    } vec_t;

    exp_t sb_q[$];
    int   n_total  = 0;
    int   n_passed = 0;
    logic [2*W-1:0] last_res;

    seq_calculator #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag   (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    // Arithmetic reference: plain operators, not the iterative algorithms.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.flag = 1'b0;
        e.lat  = 1;
        case (o)
            2'b00: e.result = 16'(x) + 16'(y);
            2'b01: begin
                e.result = {7'b0, (x < y), 8'(x - y)};
                e.flag   = (x < y);
            end
            2'b10: begin
                e.result = 16'(x) * 16'(y);
                e.lat    = W;
            end
            default: begin
                if (y == 0) begin
                    e.result = {x, 8'hFF};
                    e.flag   = 1'b1;
                end else begin
                    e.result = {8'(x % y), 8'(x / y)};
                    e.lat    = W;
                end
            end
        endcase
        return e;
    endfunction

    // Drive a request at a negedge; it is accepted on the next posedge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Compare the registered outputs against the oldest scoreboard entry.
    task automatic finish_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({name, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, " result"}, 32'(result), 32'(e.result));
            check({name, " flag"}, 32'(flag), 32'(e.flag));
            last_res = e.result;
        end
    endtask

    // Wait (bounded) for done, counting busy cycles, then score the result.
    task automatic wait_done(input string name, input int exp_lat);
        int  cyc    = 0;
        int  busy_n = 0;
        bit  seen   = 1'b0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(busy_n), 32'(exp_lat));
        if (seen) begin
            check({name, " busy at done"}, 32'(busy), 32'd0);
            finish_check(name);
        end else if (sb_q.size() != 0) begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        vec_t vecs[12];
        exp_t e;
        int   n_done;

        vecs[0]  = '{2'b00, 8'd200, 8'd100, 16'h012C, 1'b0, 1};
        vecs[1]  = '{2'b01, 8'd5,   8'd9,   16'h01FC, 1'b1, 1};
        vecs[2]  = '{2'b01, 8'd9,   8'd5,   16'h0004, 1'b0, 1};
        vecs[3]  = '{2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 8};
        vecs[4]  = '{2'b10, 8'd0,   8'd77,  16'h0000, 1'b0, 8};
        vecs[5]  = '{2'b11, 8'd200, 8'd7,   16'h041C, 1'b0, 8};
        vecs[6]  = '{2'b11, 8'h55,  8'd0,   16'h55FF, 1'b1, 1};
        vecs[7]  = '{2'b00, 8'd255, 8'd255, 16'h01FE, 1'b0, 1};
        vecs[8]  = '{2'b01, 8'd0,   8'd0,   16'h0000, 1'b0, 1};
        vecs[9]  = '{2'b11, 8'd255, 8'd1,   16'h00FF, 1'b0, 8};
        vecs[10] = '{2'b11, 8'd3,   8'd200, 16'h0300, 1'b0, 8};
        vecs[11] = '{2'b10, 8'd16,  8'd16,  16'h0100, 1'b0, 8};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        last_res = '0;

        // Reset state.
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flag", 32'(flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors with literal expectations.
        for (int i = 0; i < 12; i++) begin
            sb_q.push_back('{vecs[i].result, vecs[i].flag, vecs[i].lat});
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].lat);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
        end

        // Random vectors scored against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            e  = model(ro, ra, rb);
            sb_q.push_back(e);
            issue(ro, ra, rb);
            wait_done($sformatf("rnd%0d", i), e.lat);
            @(negedge clk);
        end

        // Handshake: start held high with changing operands during a mul.
        sb_q.push_back(model(2'b10, 8'd3, 8'd5));
        issue(2'b10, 8'd3, 8'd5);
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("hs busy%0d", i), 32'(busy), 32'd1);
            check($sformatf("hs hold%0d", i), 32'(result), 32'(last_res));
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        check("hs busy7", 32'(busy), 32'd1);
        @(negedge clk);
        check("hs done", 32'(done), 32'd1);
        finish_check("hs");

        // Back-to-back: start during the DONE cycle, no IDLE gap.
        @(negedge clk);
        sb_q.push_back(model(2'b00, 8'd1, 8'd2));
        issue(2'b00, 8'd1, 8'd2);
        @(negedge clk);
        check("b2b first busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b first done", 32'(done), 32'd1);
        finish_check("b2b first");
        sb_q.push_back(model(2'b01, 8'd7, 8'd3));
        issue(2'b01, 8'd7, 8'd3);
        check("b2b no gap", 32'(busy), 32'd1);
        wait_done("b2b second", 1);
        @(negedge clk);

        // Reset mid-divide after four iterations.
        issue(2'b11, 8'd200, 8'd7);
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst flag", 32'(flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("rst no done", 32'(n_done), 32'd0);

        // Operation after reset still works.
        sb_q.push_back(model(2'b11, 8'd200, 8'd7));
        issue(2'b11, 8'd200, 8'd7);
        wait_done("post rst div", W);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_passed, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational calculator.
- Performs unsigned add, subtract, multiply (shift-add, one partial product per cycle) and divide (restoring, one quotient bit per cycle) on WIDTH-bit operands.
- Uses a start/busy/done handshake with a registered 2*WIDTH result.
- Sits behind the team's control/register logic as a shared arithmetic unit.

Parameters:
- WIDTH, 8: operand width in bits, >= 2; result is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, do not override.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  2  00 add, 01 sub, 10 mul, 11 div.
- a  in  WIDTH  operand A (dividend for div).
- b  in  WIDTH  operand B (divisor for div).
- busy  out  1  high while an operation is in progress (CALC state).
- done  out  1  one-cycle pulse; result/flags valid from this cycle on.
- result  out  2*WIDTH  registered result.
- flag  out  1  sub: borrow (a<b); div: divide-by-zero; add/mul: 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, result=0, flag=0, FSM=IDLE, counter=0.
- Reset asserted mid-operation aborts immediately; no done pulse follows release.
- FSM states:
  - IDLE: start=1 -> latch a, b, op; go to CALC with counter=0.
  - CALC: busy=1; one iteration per edge. After the last iteration, register result/flag and go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. start=1 -> accept new operands, go to CALC (back-to-back). Else -> IDLE.
- Latency: start high before edge 0 (accept). done=1 in the cycle after edge L.
  - add, sub, div-by-zero: L=1.
  - mul, div: L=WIDTH.
- start while busy=1 is ignored; a/b/op changes while busy do not affect the operation in flight.
- result and flag hold their last value until the next done; they are never updated mid-operation.
- add: result = zero-extended a+b; the carry lands in result[WIDTH].
- sub: result[WIDTH-1:0] = (a-b) mod 2^WIDTH, result[WIDTH] = borrow, upper bits 0, flag = borrow.
- mul: 2*WIDTH accumulator. Iteration i adds (a << i) when b[i]=1. result = a*b exactly; no overflow is possible.
- div, b!=0: restoring algorithm, MSB first, WIDTH+1-bit partial remainder. result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder, flag=0.
- div, b==0: no iteration, L=1. quotient = all ones, remainder = a, flag=1.
- a=0 or b=0 for mul still takes WIDTH cycles (fixed latency, no early exit).
- op latched at accept; illegal values impossible (all 4 codes defined).

Test Plan (WIDTH=8):
- Add overflow: reset, then start, op=00, a=200, b=100 -> done one cycle after edge 1; result=16'h012C, flag=0; busy high for exactly 1 cycle.
- Sub with borrow: op=01, a=5, b=9 -> result=16'h01FC, flag=1. Then a=9, b=5 -> result=16'h0004, flag=0.
- Mul corner: op=10, a=255, b=255 -> busy high 8 cycles, done after edge 8, result=16'hFE01. Then a=0, b=77 -> result=0, still 8-cycle latency.
- Div and div-by-zero: op=11, a=200, b=7 -> result=16'h041C (rem 4, quot 28), flag=0, latency 8. Then a=8'h55, b=0 -> result=16'h55FF, flag=1, latency 1.
- Handshake: start held high with changing operands during a mul -> only the first operation runs, and result matches the original operands. start in the DONE cycle -> next op accepted with no IDLE gap.
- Reset mid-op: assert rst_n=0 at iteration 4 of a div -> busy, done, result, flag are 0 immediately (asynchronous). After release, no done pulse until a new start.
